pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PC_W, default 32, width of the program-counter field.
REQ-002 Parameter IR_W, default 32, width of the instruction field.
REQ-003 Parameter SB_W, default 32, width of the generic sideband payload (operands, control bits).
REQ-004 Parameter BUBBLE_IR, default 32'h0000_0013 (addi x0,x0,0), instruction value driven on IR_out whenever the stage holds no valid entry.
REQ-005 Port list SHALL be, in this order:
  clk        in   1      single clock, rising edge
  sync_rst   in   1      synchronous reset, active-high
  flush      in   1      discard all held entries
  in_valid   in   1      upstream entry present
  in_ready   out  1      stage accepts entry this cycle
  PC_in      in   PC_W   upstream PC
  IR_in      in   IR_W   upstream instruction
  SB_in      in   SB_W   upstream sideband
  out_valid  out  1      entry presented downstream
  out_ready  in   1      downstream accepts entry
  PC_out     out  PC_W   presented PC
  IR_out     out  IR_W   presented instruction
  SB_out     out  SB_W   presented sideband
  occupancy  out  2      number of held entries (0..2)

Function
REQ-006 Transfers SHALL occur only on rising clk edges where the respective valid and ready are both high; no other condition moves data.
REQ-007 Storage SHALL be a main register (drives outputs) plus, when configured, one skid register; entries leave in arrival order.
REQ-008 out_valid, PC_out, IR_out, SB_out SHALL be driven directly from the main register (no combinational path from inputs).
REQ-009 When main is empty, out_valid=0, PC_out=0, IR_out=BUBBLE_IR, SB_out=0.
REQ-010 Upstream transfer into empty main (or main draining the same cycle) SHALL present the entry on the next cycle: latency one cycle.
REQ-011 Main full, out_ready=0, upstream transfer: entry SHALL be written to skid; occupancy becomes 2.
REQ-012 Main drained while skid full: skid SHALL move to main the same edge; a simultaneous upstream transfer is impossible (in_ready=0).
REQ-013 Simultaneous downstream and upstream transfers with occupancy 1 SHALL keep occupancy 1, full throughput (one entry per cycle).
REQ-014 flush=1 SHALL, on that edge, empty main and skid, ignore any concurrent upstream transfer, and present the bubble per REQ-009 next cycle; in_ready is unaffected by flush.
REQ-015 A downstream transfer in the flush cycle SHALL still complete (entry was already visible).
REQ-016 occupancy SHALL equal the count of valid entries after each edge.

Reset
REQ-017 sync_rst=1 at a rising edge SHALL empty all storage: out_valid=0, PC_out=0, IR_out=BUBBLE_IR, SB_out=0, occupancy=0; overrides flush and all transfers.
REQ-018 During and in the cycle after reset, in_ready SHALL be 1.
REQ-019 Reset mid-operation (occupancy 2) SHALL drop both entries with no downstream transfer on that edge.

Configuration
REQ-020 Macro PIPE_STAGE_SKID_EN defined: skid register present, in_ready = NOT skid_valid, registered, no combinational ready path upstream.
REQ-021 Macro undefined: skid register absent, in_ready = NOT out_valid OR out_ready (combinational), occupancy never exceeds 1; all other requirements hold with occupancy 2 unreachable.

Structure
REQ-022 BUBBLE_IR default (RV_NOP) and the occupancy width SHALL live in the shared CPU package, reused by all stage instances (IF/ID, ID/EX, EX/MEM, MEM/WB).
REQ-023 No sub-module; a single flat module.

Verification
REQ-024 Reset: sync_rst pulse with occupancy 2 -> out_valid=0, IR_out=32'h13, occupancy=0, in_ready=1.
REQ-025 Streaming: in_valid=1, out_ready=1, PC 0x00,0x04,0x08 -> same PCs on PC_out one cycle later each, occupancy 1 throughout.
REQ-026 Backpressure (skid on): out_ready=0, send PC 0x10,0x14 -> occupancy 2, in_ready=0; release out_ready -> 0x10 then 0x14, no loss/duplication.
REQ-027 Flush: occupancy 2, flush=1 with in_valid=1 PC 0x20 -> next cycle out_valid=0, IR_out=32'h13, 0x20 never appears.
REQ-028 Skid off: out_ready=0, main full -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle, throughput one per cycle.
REQ-029 Random valid/ready (10k cycles, both configs) -> scoreboard order and data match, occupancy never exceeds configured maximum.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared CPU pipeline definitions reused by every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB).
package pipe_stage_reg_pkg;
   localparam logic [31:0] RV_NOP = 32'h0000_0013;
   localparam int          OCC_W  = 2;
   typedef logic [OCC_W-1:0] occ_t;
endpackage

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with bubble injection and flush.
// Define PIPE_STAGE_SKID_EN to add a skid register, which makes in_ready fully registered.
module pipe_stage_reg
   import pipe_stage_reg_pkg::*;
#(
   parameter int              PC_W      = 32,
   parameter int              IR_W      = 32,
   parameter int              SB_W      = 32,
   parameter logic [IR_W-1:0] BUBBLE_IR = IR_W'(RV_NOP)
) (
   input  logic            clk,
   input  logic            sync_rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [PC_W-1:0] PC_in,
   input  logic [IR_W-1:0] IR_in,
   input  logic [SB_W-1:0] SB_in,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] PC_out,
   output logic [IR_W-1:0] IR_out,
   output logic [SB_W-1:0] SB_out,
   output occ_t            occupancy
);

   logic            r_main_vld;
   logic [PC_W-1:0] r_main_pc;
   logic [IR_W-1:0] r_main_ir;
   logic [SB_W-1:0] r_main_sb;

   logic            w_main_free;
   logic            w_src_vld;
   logic [PC_W-1:0] w_src_pc;
   logic [IR_W-1:0] w_src_ir;
   logic [SB_W-1:0] w_src_sb;

   assign w_main_free = ~r_main_vld | out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic            r_skid_vld;
   logic [PC_W-1:0] r_skid_pc;
   logic [IR_W-1:0] r_skid_ir;
   logic [SB_W-1:0] r_skid_sb;
   logic            w_skid_load;

   // Reset forces ready high so upstream sees a free stage while reset is held.
   assign in_ready    = ~r_skid_vld | sync_rst;
   assign w_skid_load = ~r_skid_vld & in_valid & r_main_vld & ~out_ready;
   assign occupancy   = OCC_W'(r_main_vld) + OCC_W'(r_skid_vld);

   // A held skid entry is older than anything upstream, so it refills main first.
   assign w_src_vld = r_skid_vld | (in_valid & in_ready);
   assign w_src_pc  = r_skid_vld ? r_skid_pc : PC_in;
   assign w_src_ir  = r_skid_vld ? r_skid_ir : IR_in;
   assign w_src_sb  = r_skid_vld ? r_skid_sb : SB_in;

   always_ff @(posedge clk) begin
      if (sync_rst || flush) begin
         r_skid_vld <= 1'b0;
      end else if (r_skid_vld) begin
         if (out_ready) r_skid_vld <= 1'b0;
      end else if (w_skid_load) begin
         r_skid_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_skid_load) begin
         r_skid_pc <= PC_in;
         r_skid_ir <= IR_in;
         r_skid_sb <= SB_in;
      end
   end
`else
   assign in_ready  = ~r_main_vld | out_ready | sync_rst;
   assign occupancy = OCC_W'(r_main_vld);
   assign w_src_vld = in_valid & in_ready;
   assign w_src_pc  = PC_in;
   assign w_src_ir  = IR_in;
   assign w_src_sb  = SB_in;
`endif

   // Empty main holds the bubble values so outputs come straight from flops.
   always_ff @(posedge clk) begin
      if (sync_rst || flush) begin
         r_main_vld <= 1'b0;
         r_main_pc  <= '0;
         r_main_ir  <= BUBBLE_IR;
         r_main_sb  <= '0;
      end else if (w_main_free) begin
         if (w_src_vld) begin
            r_main_vld <= 1'b1;
            r_main_pc  <= w_src_pc;
            r_main_ir  <= w_src_ir;
            r_main_sb  <= w_src_sb;
         end else begin
            r_main_vld <= 1'b0;
            r_main_pc  <= '0;
            r_main_ir  <= BUBBLE_IR;
            r_main_sb  <= '0;
         end
      end
   end

   assign out_valid = r_main_vld;
   assign PC_out    = r_main_pc;
   assign IR_out    = r_main_ir;
   assign SB_out    = r_main_sb;

endmodule
